// File: rtl/dav_rfd_byte_serializer.sv
// dav_rfd_byte_serializer: buffers 32-bit dav_/rfd words in a small FIFO and
// re-emits each one LSB-first as four dav_/rfd byte transfers.
module dav_rfd_byte_serializer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          dav_,
    input  logic [31:0]   q,
    output logic          rfd,
    output logic [7:0]    byte_out,
    output logic          dav_out_,
    input  logic          rfd_in,
    output logic [AW:0]   count
);
    typedef enum logic {IN_IDLE, IN_ACK} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE, OUT_VALID, OUT_RELEASE} out_state_e;

    in_state_e     in_q, in_d;
    out_state_e    out_q, out_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [AW:0]   count_q, count_d;
    logic          rfd_q, rfd_d, dav_out_q, dav_out_d;
    logic [7:0]    byte_q, byte_d;
    logic          wr, pop;
    logic [31:0]   rd_word;

    always_comb begin
        wr        = in_q == IN_IDLE && !dav_ && count_q != (AW+1)'(DEPTH);
        pop       = out_q == OUT_RELEASE && rfd_in && idx_q == 2'd3;
        rd_word   = mem_q[rptr_q];
        in_d      = in_q;
        rfd_d     = rfd_q;
        out_d     = out_q;
        dav_out_d = dav_out_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        wptr_d    = wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
        count_d   = count_q + (AW+1)'(wr) - (AW+1)'(pop);
        if (wr) begin
            in_d  = IN_ACK;
            rfd_d = 1'b0;
        end else if (in_q == IN_ACK && dav_) begin
            in_d  = IN_IDLE;
            rfd_d = 1'b1;
        end
        // idx wraps 3 -> 0 on its own, matching the pop of the finished word
        case (out_q)
            OUT_IDLE: if (count_q != '0) begin
                byte_d    = rd_word[8*idx_q +: 8];
                dav_out_d = 1'b0;
                out_d     = OUT_VALID;
            end
            OUT_VALID: if (!rfd_in) begin
                dav_out_d = 1'b1;
                out_d     = OUT_RELEASE;
            end
            OUT_RELEASE: if (rfd_in) begin
                idx_d = idx_q + 1'b1;
                out_d = OUT_IDLE;
            end
            default: out_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clock)
        if (wr) mem_q[wptr_q] <= q;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            in_q      <= IN_IDLE;
            out_q     <= OUT_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            rfd_q     <= 1'b1;
            dav_out_q <= 1'b1;
            byte_q    <= '0;
        end else begin
            in_q      <= in_d;
            out_q     <= out_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            rfd_q     <= rfd_d;
            dav_out_q <= dav_out_d;
            byte_q    <= byte_d;
        end
    end

    assign rfd      = rfd_q;
    assign dav_out_ = dav_out_q;
    assign byte_out = byte_q;
    assign count    = count_q;
endmodule

// File: tb/tb_dav_rfd_byte_serializer.sv
// tb_dav_rfd_byte_serializer: drives random words upstream and checks the byte
// stream against an expected-byte queue filled when each word is captured.
module tb_dav_rfd_byte_serializer;
    logic        clock = 1'b0;
    logic        reset_ = 1'b1;
    logic        dav_ = 1'b1;
    logic [31:0] q = '0;
    logic        rfd;
    logic [7:0]  byte_out;
    logic        dav_out_;
    logic        rfd_in = 1'b1;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    dav_rfd_byte_serializer #(.DEPTH(4), .AW(2)) dut (
        .clock(clock), .reset_(reset_), .dav_(dav_), .q(q), .rfd(rfd),
        .byte_out(byte_out), .dav_out_(dav_out_), .rfd_in(rfd_in), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] w, input int dly);
        q = w;
        dav_ = 1'b0;
        for (int n = 0; n < 1000 && rfd !== 1'b0; n++) @(negedge clock);
        chk("capture", rfd, 0);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        repeat (dly) @(negedge clock);
        dav_ = 1'b1;
        @(negedge clock);
        chk("rfd_release", rfd, 1);
    endtask

    task automatic take_byte(input int dly, input bit rel);
        logic [7:0] got, exp;
        for (int n = 0; n < 1000 && dav_out_ !== 1'b0; n++) @(negedge clock);
        if (dav_out_ !== 1'b0) chk("byte_timeout", dav_out_, 0);
        got = byte_out;
        exp = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
        chk("byte", got, exp);
        repeat (dly) @(negedge clock);
        chk("byte_hold", byte_out, got);
        rfd_in = 1'b0;
        for (int n = 0; n < 1000 && dav_out_ !== 1'b1; n++) @(negedge clock);
        chk("dav_out_rise", dav_out_, 1);
        if (rel) begin
            repeat (dly) @(negedge clock);
            rfd_in = 1'b1;
        end
    endtask

    // protocol monitors: inputs sampled at the active edge, outputs after it
    logic dav_s = 1'b1, ack_ok = 1'b1, ack_prev = 1'b1, rfd_p = 1'b1, dvo_p = 1'b1;
    always @(posedge clock) begin
        ack_prev = ack_ok;
        dav_s = dav_;
        if (rfd_in && dav_out_) ack_ok = 1'b1;
    end
    always @(negedge clock) begin
        if (!reset_) ack_ok = 1'b1;
        else begin
            if (rfd_p && !rfd) chk("rfd_fall_needs_dav", dav_s, 0);
            if (dvo_p && !dav_out_) begin
                chk("dav_out_order", ack_prev, 1);
                ack_ok = 1'b0;
            end
        end
        rfd_p = rfd;
        dvo_p = dav_out_;
    end

    initial begin
        #1 reset_ = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_rfd", rfd, 1);
        chk("rst_dav_out", dav_out_, 1);
        chk("rst_byte", byte_out, 0);
        chk("rst_count", count, 0);
        reset_ = 1'b1;
        @(negedge clock);

        // single word, count drops at the edge seeing the final rfd_in=1
        send(32'h0001_FE01, 2);
        repeat (3) take_byte(1, 1);
        take_byte(1, 0);
        chk("single_cnt_before", count, 1);
        rfd_in = 1'b1;
        @(negedge clock);
        chk("single_cnt_after", count, 0);

        // full FIFO back-pressure
        for (int k = 1; k <= 4; k++) send(32'h1111_1111 * k, 0);
        chk("full_count", count, 4);
        q = 32'h5555_5555;
        dav_ = 1'b0;
        repeat (5) @(negedge clock);
        chk("full_rfd_held", rfd, 1);
        chk("full_count_held", count, 4);
        fork
            begin
                for (int n = 0; n < 1000 && rfd !== 1'b0; n++) @(negedge clock);
                chk("full_capture", rfd, 0);
                chk("full_count_refill", count, 4);
                for (int b = 0; b < 4; b++) exp_q.push_back(q[8*b +: 8]);
                dav_ = 1'b1;
                @(negedge clock);
            end
            repeat (4) take_byte(1, 1);
        join
        repeat (16) take_byte(0, 1);
        @(negedge clock);
        chk("full_drained", count, 0);

        // push and pop on the same edge
        send(32'hA1B2_C3D4, 0);
        repeat (3) take_byte(0, 1);
        take_byte(0, 0);
        q = 32'h0F1E_2D3C;
        dav_ = 1'b0;
        rfd_in = 1'b1;
        @(negedge clock);
        chk("pp_count", count, 1);
        chk("pp_rfd", rfd, 0);
        for (int b = 0; b < 4; b++) exp_q.push_back(q[8*b +: 8]);
        dav_ = 1'b1;
        @(negedge clock);
        chk("pp_rfd_release", rfd, 1);
        repeat (4) take_byte(0, 1);
        @(negedge clock);
        chk("pp_drained", count, 0);

        // wrap-around with a fast sink
        fork
            for (int k = 0; k < 10; k++) send(32'h0101_0101 * k, 0);
            repeat (40) take_byte(0, 1);
        join
        @(negedge clock);
        chk("wrap_drained", count, 0);

        // random words and random handshake delays on both sides
        fork
            for (int k = 0; k < 30; k++) begin
                send($urandom, $urandom_range(0, 3));
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            repeat (120) take_byte($urandom_range(0, 3), 1);
        join
        @(negedge clock);
        chk("rand_drained", count, 0);
        chk("rand_queue_empty", exp_q.size(), 0);

        // asynchronous reset mid-byte
        send(32'hDEAD_BEEF, 0);
        send(32'hCAFE_F00D, 0);
        @(negedge clock);
        chk("pre_rst_dav_out", dav_out_, 0);
        chk("pre_rst_count", count, 2);
        #2 reset_ = 1'b0;
        #1;
        chk("arst_dav_out", dav_out_, 1);
        chk("arst_rfd", rfd, 1);
        chk("arst_count", count, 0);
        chk("arst_byte", byte_out, 0);
        exp_q.delete();
        @(negedge clock);
        reset_ = 1'b1;
        repeat (10) @(negedge clock);
        chk("post_rst_quiet", dav_out_, 1);
        chk("post_rst_count", count, 0);
        send(32'h7654_3210, 1);
        repeat (4) take_byte(1, 1);
        @(negedge clock);
        chk("post_rst_drained", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
